// File: rtl/rv32_pkg.sv
// Shared RV32 types and constants for the fetch front end.
package rv32_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic        epoch;
    logic [31:0] pc;
  } fetch_tag_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO with a combinational head; push and pop are legal together
// at any occupancy, and flush empties it, dropping any same-cycle push.
module if_fetch_fifo
  import rv32_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  T              wdata,
  input  logic          pop,
  input  logic          flush,
  output T              rdata,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          do_push, do_pop;
  T              mem_reg [DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && !flush && ((count_reg != CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= wdata;
  end

  assign rdata = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: credit-limited imem requests, epoch-tagged in-order
// responses, instruction buffer towards ID. Optional FETCH_PERF_CNT_EN adds perf counters.
module if_fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic            epoch_reg, epoch_next;
  logic [OW-1:0]   outstanding;
  logic [FW-1:0]   fifo_count;
  logic            tag_empty, fifo_empty;
  logic            credit_ok, accept, rsp_pop, rsp_keep;
  fetch_tag_t      tag_wdata, tag_head;
  fetch_entry_t    fifo_wdata, fifo_head;

  // Every request in flight already owns a buffer slot, so the buffer cannot overflow.
  assign credit_ok = (int'(outstanding) < MAX_OUTSTANDING) &&
                     ((int'(outstanding) + int'(fifo_count)) < FIFO_DEPTH);
  assign imem_req  = reset && !redirect_valid && credit_ok;
  assign imem_addr = fetch_pc_reg;
  assign accept    = imem_req && imem_gnt;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    epoch_next    = epoch_reg;
    if (redirect_valid) begin
      fetch_pc_next = {redirect_pc[31:2], 2'b00};
      epoch_next    = !epoch_reg;
    end else if (accept) begin
      fetch_pc_next = fetch_pc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg <= RESET_PC;
      epoch_reg    <= 1'b0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      epoch_reg    <= epoch_next;
    end
  end

  // Tag queue: its occupancy is the outstanding-request count; never flushed so that
  // stale responses keep their credit until they come back.
  assign tag_wdata = '{epoch: epoch_reg, pc: fetch_pc_reg};
  assign rsp_pop   = imem_rvalid && !tag_empty;

  if_fetch_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (fetch_tag_t)
  ) u_tag_q (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .wdata (tag_wdata),
    .pop   (rsp_pop),
    .flush (1'b0),
    .rdata (tag_head),
    .empty (tag_empty),
    .count (outstanding)
  );

  // A response from before the last redirect carries the old epoch and is dropped.
  assign rsp_keep   = rsp_pop && (tag_head.epoch == epoch_reg);
  assign fifo_wdata = '{pc: tag_head.pc, instr: imem_rdata};

  if_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_instr_q (
    .clk   (clk),
    .reset (reset),
    .push  (rsp_keep),
    .wdata (fifo_wdata),
    .pop   (id_valid && id_ready),
    .flush (redirect_valid),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign id_valid = !fifo_empty;
  assign id_pc    = id_valid ? fifo_head.pc    : '0;
  assign id_instr = id_valid ? fifo_head.instr : '0;

  a_rvalid_has_request : assert property (
    @(posedge clk) disable iff (!reset) imem_rvalid |-> !tag_empty
  ) else $error("imem_rvalid with no outstanding request");

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt_reg <= '0;
      flush_cnt_reg  <= '0;
    end else begin
      if (id_ready && !id_valid && (bubble_cnt_reg != 32'hFFFF_FFFF))
        bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
      if (redirect_valid && (flush_cnt_reg != 32'hFFFF_FFFF))
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign perf_bubble_cnt = bubble_cnt_reg;
  assign perf_flush_cnt  = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; the imem model answers with latency 1 and
// returns rdata = addr ^ 32'h13 unless held.
module tb_if_fetch_stage;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'd0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic        mem_hold;
  logic        acc_q = 1'b0;
  logic [31:0] acc_addr = 32'd0;
  logic [31:0] pend [$];

  if_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_bubble_cnt(perf_bubble_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Note which request the coming edge will accept, well after inputs settle.
  always @(negedge clk) begin
    #2;
    acc_q    = imem_req && imem_gnt;
    acc_addr = imem_addr;
  end

  always @(posedge clk) begin
    #1;
    if (acc_q) pend.push_back(acc_addr);
    acc_q = 1'b0;
    if (!mem_hold && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend.pop_front() ^ INSTR_NOP;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the next instruction on ID, check it, then step past its pop.
  task automatic expect_id(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    int n = 0;
    while (!id_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(id_valid), 32'd1);
    if (id_valid) begin
      $display("id  %s pc=%08h instr=%08h", tag, id_pc, id_instr);
      check({tag, "_pc"}, id_pc, pc);
      check({tag, "_instr"}, id_instr, instr);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    mem_hold       = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    imem_gnt       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    id_ready       = 1'b1;
    mem_hold       = 1'b0;

    // Reset state and first fetches
    @(negedge clk);
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_pc",    id_pc,         32'd0);
    check("rst_instr", id_instr,      32'd0);
    check("rst_addr",  imem_addr,     32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t1_req",  32'(imem_req), 32'd1);
    check("t1_addr", imem_addr,     32'h0);
    @(negedge clk);
    check("t1_valid_early", 32'(id_valid), 32'd0);
    check("t1_addr_adv",    imem_addr,     32'h4);
    @(negedge clk);
    check("t1_credit_stall", 32'(imem_req), 32'd0);
    expect_id("t1_0", 32'h0, 32'h13);
    expect_id("t1_4", 32'h4, 32'h17);
    expect_id("t1_8", 32'h8, 32'h1B);
    expect_id("t1_c", 32'hC, 32'h1F);

    // Grant withheld: address held, no progress
    imem_gnt = 1'b0;
    do_reset();
    repeat (3) begin
      @(negedge clk);
      check("t2_req",   32'(imem_req), 32'd1);
      check("t2_addr",  imem_addr,     32'h0);
      check("t2_valid", 32'(id_valid), 32'd0);
    end
    imem_gnt = 1'b1;
    expect_id("t2_0", 32'h0, 32'h13);

    // ID stalled: credits run out with 0x0/0x4 buffered
    id_ready = 1'b0;
    do_reset();
    repeat (5) @(negedge clk);
    check("t3_req",   32'(imem_req), 32'd0);
    check("t3_addr",  imem_addr,     32'h8);
    check("t3_valid", 32'(id_valid), 32'd1);
    check("t3_head",  id_pc,         32'h0);
    id_ready = 1'b1;
    expect_id("t3_0", 32'h0, 32'h13);
    expect_id("t3_4", 32'h4, 32'h17);
    expect_id("t3_8", 32'h8, 32'h1B);

    // Redirect with 0x8/0xC in flight
    do_reset();
    expect_id("t4_0", 32'h0, 32'h13);
    mem_hold = 1'b1;
    expect_id("t4_4", 32'h4, 32'h17);
    @(negedge clk);
    check("t4_req_full", 32'(imem_req), 32'd0);
    check("t4_addr_pre", imem_addr,     32'h10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t4_addr_redir", imem_addr,     32'h40);
    check("t4_req_stale",  32'(imem_req), 32'd0);
    check("t4_valid",      32'(id_valid), 32'd0);
    mem_hold = 1'b0;
    expect_id("t4_40", 32'h40, 32'h53);
    expect_id("t4_44", 32'h44, 32'h57);

    // Back-to-back redirects, then address wrap
    do_reset();
    expect_id("t5_0", 32'h0, 32'h13);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    check("t5_req_gated", 32'(imem_req), 32'd0);
    @(negedge clk);
    redirect_pc = 32'h200;
    check("t5_addr_100", imem_addr,     32'h100);
    check("t5_valid",    32'(id_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t5_addr_200", imem_addr, 32'h200);
    expect_id("t5_200", 32'h200, 32'h213);
    expect_id("t5_204", 32'h204, 32'h217);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    expect_id("t5_top",  32'hFFFF_FFFC, 32'hFFFF_FFEF);
    expect_id("t5_wrap", 32'h0,         32'h13);

    // Asynchronous reset with two requests outstanding
    do_reset();
    mem_hold = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_req_full", 32'(imem_req), 32'd0);
    check("t6_addr_pre", imem_addr,     32'h8);
    #3;
    reset    = 1'b0;
    mem_hold = 1'b0;
    #1;
    check("t6_addr_rst",  imem_addr,     32'h0);
    check("t6_req_rst",   32'(imem_req), 32'd0);
    check("t6_valid_rst", 32'(id_valid), 32'd0);
    check("t6_pc_rst",    id_pc,         32'd0);
    repeat (4) @(negedge clk);
    check("t6_valid_late", 32'(id_valid), 32'd0);
    reset = 1'b1;
    #1;
    check("t6_req_restart", 32'(imem_req), 32'd1);
    check("t6_addr_restart", imem_addr,    32'h0);
    expect_id("t6_0", 32'h0, 32'h13);
    expect_id("t6_4", 32'h4, 32'h17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
